// File: rtl/cpu_pkg.sv
// Shared definitions for the 9-bit machine: widths, opcode map, fetch FSM states.
package cpu_pkg;

  localparam int unsigned PC_W      = 10;
  localparam int unsigned IW        = 9;
  localparam int unsigned LUT_IDX_W = 3;

  typedef enum logic [2:0] {
    OpAnd   = 3'b000,
    OpAdd   = 3'b001,
    OpXor   = 3'b010,
    OpBne   = 3'b011,
    OpLs    = 3'b100,
    OpRs    = 3'b101,
    OpLoad  = 3'b110,
    OpStore = 3'b111
  } opcode_t;

  typedef enum logic [1:0] {
    StIdle = 2'b00,
    StRun  = 2'b01,
    StHalt = 2'b10
  } fetch_state_t;

  // bne carries its branch-target index in the low bits of the word
  function automatic logic [LUT_IDX_W-1:0] lut_idx(input logic [IW-1:0] instr);
    return instr[LUT_IDX_W-1:0];
  endfunction

endpackage

// File: rtl/branch_lut.sv
// Branch target table: maps a 3-bit label index to an absolute PC.
// This table mirrors the assembler's label map; keep the two in sync.
module branch_lut
  import cpu_pkg::*;
(
  input  logic [LUT_IDX_W-1:0] idx_i,
  output logic [PC_W-1:0]      target_o
);

  // Combinational label lookup
  always_comb begin
    target_o = '0;
    case (idx_i)
      3'd0:    target_o = 10'h000;
      3'd1:    target_o = 10'h004;
      3'd2:    target_o = 10'h010;
      3'd3:    target_o = 10'h3ff;
      3'd4:    target_o = 10'h100;
      3'd5:    target_o = 10'h020;
      3'd6:    target_o = 10'h055;
      3'd7:    target_o = 10'h200;
      default: target_o = '0;
    endcase
  end

endmodule

// File: rtl/fetch_unit.sv
// Fetch unit: owns the PC, drives instruction memory, resolves sequential and
// bne targets, sequences IDLE -> RUN -> HALT and counts retired instructions.
module fetch_unit
  import cpu_pkg::*;
#(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic             start_i,
  input  logic [PC_W-1:0]  start_addr_i,
  input  logic [PC_W-1:0]  end_addr_i,
  input  logic             stall_i,
  input  logic             branch_i,
  input  logic             not_equal_i,
  input  logic [IW-1:0]    imem_data_i,
  output logic [PC_W-1:0]  imem_addr_o,
  output logic [IW-1:0]    instr_o,
  output logic             running_o,
  output logic             done_o,
  output logic [CNT_W-1:0] inst_count_o
);

  fetch_state_t     state_q;
  logic [PC_W-1:0]  pc_q, pc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             running_q, done_q;
  logic [PC_W-1:0]  lut_target;
  logic             halt_now;

  branch_lut u_branch_lut (
    .idx_i    (lut_idx(instr_o)),
    .target_o (lut_target)
  );

  // Decoder never sees stale opcodes outside RUN
  assign instr_o = running_q ? imem_data_i : '0;

  // Next-PC resolution, saturating retire count and halt detection
  always_comb begin
    pc_d  = pc_q + PC_W'(1);
    if (branch_i && not_equal_i) begin
      pc_d = lut_target;
    end
    cnt_d = (&cnt_q) ? cnt_q : cnt_q + CNT_W'(1);
    // pc_q can only equal end_addr in RUN when the program started there
    halt_now = (pc_d == end_addr_i) || (pc_q == end_addr_i);
  end

  // Fetch FSM with registered status outputs
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q   <= StIdle;
      pc_q      <= '0;
      cnt_q     <= '0;
      running_q <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      case (state_q)
        StIdle, StHalt: begin
          if (start_i) begin
            state_q   <= StRun;
            pc_q      <= start_addr_i;
            cnt_q     <= '0;
            running_q <= 1'b1;
            done_q    <= 1'b0;
          end
        end
        StRun: begin
          if (!stall_i) begin
            pc_q  <= pc_d;
            cnt_q <= cnt_d;
            if (halt_now) begin
              state_q   <= StHalt;
              running_q <= 1'b0;
              done_q    <= 1'b1;
            end
          end
        end
        default: begin
          state_q   <= StIdle;
          running_q <= 1'b0;
          done_q    <= 1'b0;
        end
      endcase
    end
  end

  assign imem_addr_o  = pc_q;
  assign running_o    = running_q;
  assign done_o       = done_q;
  assign inst_count_o = cnt_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: table-driven per-cycle vectors through a scoreboard
// queue, plus hand-written async-reset and counter-saturation sequences.
module tb_fetch_unit;

  logic       clk;
  logic       reset_i;
  logic       start_i;
  logic [9:0] start_addr_i;
  logic [9:0] end_addr_i;
  logic       stall_i;
  logic       branch_i;
  logic       not_equal_i;

  logic [8:0]  mem [1024];
  logic [8:0]  imem_data, imem_data_s;
  logic [9:0]  imem_addr, imem_addr_s;
  logic [8:0]  instr, instr_s;
  logic        running, running_s, done, done_s;
  logic [15:0] cnt;
  logic [3:0]  cnt_s;

  int n_pass = 0;
  int n_total = 0;

  assign imem_data   = mem[imem_addr];
  assign imem_data_s = mem[imem_addr_s];

  fetch_unit u_dut (
    .clk_i        (clk),
    .reset_i      (reset_i),
    .start_i      (start_i),
    .start_addr_i (start_addr_i),
    .end_addr_i   (end_addr_i),
    .stall_i      (stall_i),
    .branch_i     (branch_i),
    .not_equal_i  (not_equal_i),
    .imem_data_i  (imem_data),
    .imem_addr_o  (imem_addr),
    .instr_o      (instr),
    .running_o    (running),
    .done_o       (done),
    .inst_count_o (cnt)
  );

  fetch_unit #(.CNT_W(4)) u_dut_sat (
    .clk_i        (clk),
    .reset_i      (reset_i),
    .start_i      (start_i),
    .start_addr_i (start_addr_i),
    .end_addr_i   (end_addr_i),
    .stall_i      (stall_i),
    .branch_i     (branch_i),
    .not_equal_i  (not_equal_i),
    .imem_data_i  (imem_data_s),
    .imem_addr_o  (imem_addr_s),
    .instr_o      (instr_s),
    .running_o    (running_s),
    .done_o       (done_s),
    .inst_count_o (cnt_s)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        start;
    logic [9:0]  sa;
    logic [9:0]  ea;
    logic        stall;
    logic        br;
    logic        ne;
    logic [9:0]  e_addr;
    logic [8:0]  e_instr;
    logic        e_run;
    logic        e_done;
    logic [15:0] e_cnt;
  } vec_t;

  typedef struct {
    int          row;
    logic [9:0]  addr;
    logic [8:0]  instr;
    logic        run;
    logic        done;
    logic [15:0] cnt;
  } exp_t;

  localparam int NV = 25;
  localparam int RST_AT = 21;
  vec_t vecs [NV];
  exp_t sb [$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    else n_pass++;
  endtask

  function automatic vec_t mk(input logic st, input logic [9:0] sa, input logic [9:0] ea,
                              input logic stl, input logic br, input logic ne,
                              input logic [9:0] a, input logic [8:0] ins, input logic r,
                              input logic d, input logic [15:0] c);
    vec_t v;
    v.start = st; v.sa = sa; v.ea = ea; v.stall = stl; v.br = br; v.ne = ne;
    v.e_addr = a; v.e_instr = ins; v.e_run = r; v.e_done = d; v.e_cnt = c;
    return v;
  endfunction

  task automatic check_outputs(input string tag, input logic [9:0] a, input logic [8:0] ins,
                               input logic r, input logic d, input logic [15:0] c);
    check({tag, ".addr"},  32'(imem_addr), 32'(a));
    check({tag, ".instr"}, 32'(instr),     32'(ins));
    check({tag, ".run"},   32'(running),   32'(r));
    check({tag, ".done"},  32'(done),      32'(d));
    check({tag, ".cnt"},   32'(cnt),       32'(c));
  endtask

  // Async reset in the middle of a cycle while running at 0x55
  task automatic mid_run_reset();
    #3;
    reset_i = 1'b1;
    #1;
    check_outputs("async_rst", 10'h000, 9'h000, 1'b0, 1'b0, 16'd0);
    @(posedge clk); #1;
    reset_i = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    check_outputs("idle_after_rst", 10'h000, 9'h000, 1'b0, 1'b0, 16'd0);
  endtask

  initial begin
    exp_t e;
    int   waited;

    for (int i = 0; i < 1024; i++) mem[i] = 9'h001;
    mem[2] = 9'b011_000_101;  // bne, lut index 5
    mem[8] = 9'b011_000_110;  // bne, lut index 6

    //              st  sa      ea      stl br ne  addr    instr   run done cnt
    vecs[0]  = mk(1, 10'h000, 10'h004, 0, 0, 0, 10'h000, 9'h001, 1, 0, 0);
    vecs[1]  = mk(0, 10'h000, 10'h004, 0, 0, 0, 10'h001, 9'h001, 1, 0, 1);
    vecs[2]  = mk(0, 10'h000, 10'h004, 0, 0, 0, 10'h002, 9'h0c5, 1, 0, 2);
    vecs[3]  = mk(0, 10'h000, 10'h004, 0, 0, 0, 10'h003, 9'h001, 1, 0, 3);
    vecs[4]  = mk(0, 10'h000, 10'h004, 0, 0, 0, 10'h004, 9'h000, 0, 1, 4);
    vecs[5]  = mk(0, 10'h000, 10'h004, 0, 0, 0, 10'h004, 9'h000, 0, 1, 4);
    vecs[6]  = mk(1, 10'h002, 10'h004, 0, 0, 0, 10'h002, 9'h0c5, 1, 0, 0);
    vecs[7]  = mk(0, 10'h002, 10'h004, 0, 1, 1, 10'h020, 9'h001, 1, 0, 1);
    vecs[8]  = mk(0, 10'h002, 10'h004, 0, 0, 0, 10'h021, 9'h001, 1, 0, 2);
    vecs[9]  = mk(0, 10'h002, 10'h004, 0, 1, 1, 10'h004, 9'h000, 0, 1, 3);
    vecs[10] = mk(1, 10'h002, 10'h300, 0, 0, 0, 10'h002, 9'h0c5, 1, 0, 0);
    vecs[11] = mk(0, 10'h002, 10'h300, 0, 1, 0, 10'h003, 9'h001, 1, 0, 1);
    vecs[12] = mk(1, 10'h100, 10'h300, 0, 0, 0, 10'h004, 9'h001, 1, 0, 2);
    vecs[13] = mk(0, 10'h100, 10'h300, 0, 0, 0, 10'h005, 9'h001, 1, 0, 3);
    vecs[14] = mk(0, 10'h100, 10'h300, 0, 0, 0, 10'h006, 9'h001, 1, 0, 4);
    vecs[15] = mk(0, 10'h100, 10'h300, 0, 0, 0, 10'h007, 9'h001, 1, 0, 5);
    vecs[16] = mk(0, 10'h100, 10'h300, 1, 1, 1, 10'h007, 9'h001, 1, 0, 5);
    vecs[17] = mk(0, 10'h100, 10'h300, 1, 0, 0, 10'h007, 9'h001, 1, 0, 5);
    vecs[18] = mk(0, 10'h100, 10'h300, 1, 0, 0, 10'h007, 9'h001, 1, 0, 5);
    vecs[19] = mk(0, 10'h100, 10'h300, 0, 0, 0, 10'h008, 9'h0c6, 1, 0, 6);
    vecs[20] = mk(0, 10'h100, 10'h300, 0, 1, 1, 10'h055, 9'h001, 1, 0, 7);
    vecs[21] = mk(1, 10'h010, 10'h010, 0, 0, 0, 10'h010, 9'h001, 1, 0, 0);
    vecs[22] = mk(0, 10'h010, 10'h010, 0, 0, 0, 10'h011, 9'h000, 0, 1, 1);
    vecs[23] = mk(1, 10'h010, 10'h010, 0, 0, 0, 10'h010, 9'h001, 1, 0, 0);
    vecs[24] = mk(0, 10'h010, 10'h010, 0, 0, 0, 10'h011, 9'h000, 0, 1, 1);

    reset_i = 1'b1;
    start_i = 1'b0; start_addr_i = '0; end_addr_i = '0;
    stall_i = 1'b0; branch_i = 1'b0; not_equal_i = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_outputs("reset", 10'h000, 9'h000, 1'b0, 1'b0, 16'd0);
    reset_i = 1'b0;
    @(posedge clk); #1;

    for (int i = 0; i < NV; i++) begin
      if (i == RST_AT) begin
        start_i = 1'b0; stall_i = 1'b0; branch_i = 1'b0; not_equal_i = 1'b0;
        mid_run_reset();
      end
      start_i      = vecs[i].start;
      start_addr_i = vecs[i].sa;
      end_addr_i   = vecs[i].ea;
      stall_i      = vecs[i].stall;
      branch_i     = vecs[i].br;
      not_equal_i  = vecs[i].ne;
      sb.push_back('{row: i, addr: vecs[i].e_addr, instr: vecs[i].e_instr,
                     run: vecs[i].e_run, done: vecs[i].e_done, cnt: vecs[i].e_cnt});
      @(posedge clk); #1;
      e = sb.pop_front();
      check_outputs($sformatf("row%0d", e.row), e.addr, e.instr, e.run, e.done, e.cnt);
    end

    // 20-instruction straight-line program; the 4-bit counter must stick at 15
    start_i = 1'b1; start_addr_i = 10'h100; end_addr_i = 10'h114;
    stall_i = 1'b0; branch_i = 1'b0; not_equal_i = 1'b0;
    @(posedge clk); #1;
    start_i = 1'b0;
    waited = 0;
    while (!done_s && waited < 100) begin
      @(posedge clk); #1;
      waited++;
    end
    check("sat.done",  32'(done_s),      32'd1);
    check("sat.cnt",   32'(cnt_s),       32'd15);
    check("sat.addr",  32'(imem_addr_s), 32'h114);
    check("sat.run",   32'(running_s),   32'd0);
    check("wide.cnt",  32'(cnt),         32'd20);
    check("wide.done", 32'(done),        32'd1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
